power_seq_ctrl: RTL and testbench

- Multi-rail power sequencer that drives the enables of NUM_RAILS downstream power_on rails in order.
- Powers rails up in ascending index order and down in descending order.
- Power-up: each rail's power good must be stable for SETTLE_CYC clocks before the next rail is enabled; a power good glitch restarts that wait.
- Sits between the system power request and the per-rail power_on blocks; reports overall power OK and latches faults.

---
 rtl/power_seq_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_power_seq_ctrl.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/power_seq_ctrl.sv
// Multi-rail power sequencer: enables rails in ascending order once each power good
// has settled, disables them in descending order, and latches power-good faults.
module power_seq_ctrl #(
    parameter int NUM_RAILS      = 4,
    parameter int SETTLE_CYC     = 30,
    parameter int PG_TIMEOUT_CYC = 1000,
    parameter int OFF_GAP_CYC    = 10,
    localparam int IDX_W = (NUM_RAILS > 1) ? $clog2(NUM_RAILS) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sys_on,
    input  logic [NUM_RAILS-1:0] pg,
    output logic [NUM_RAILS-1:0] rail_en,
    output logic                 pwr_ok,
    output logic                 busy,
    output logic                 fault,
    output logic [IDX_W-1:0]     fault_rail,
    output logic [2:0]           dbg_state
);

    localparam int MAX_AB  = (SETTLE_CYC > PG_TIMEOUT_CYC) ? SETTLE_CYC : PG_TIMEOUT_CYC;
    localparam int MAX_CNT = (MAX_AB > OFF_GAP_CYC) ? MAX_AB : OFF_GAP_CYC;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);

    localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(PG_TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(OFF_GAP_CYC - 1);
    localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(NUM_RAILS - 1);
    localparam logic [NUM_RAILS-1:0] ONE_HOT0 = NUM_RAILS'(1);

    localparam logic [2:0] S_OFF     = 3'd0;
    localparam logic [2:0] S_WAIT_PG = 3'd1;
    localparam logic [2:0] S_SETTLE  = 3'd2;
    localparam logic [2:0] S_ON      = 3'd3;
    localparam logic [2:0] S_DOWN    = 3'd4;
    localparam logic [2:0] S_FAULT   = 3'd5;

    logic [2:0]           state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [NUM_RAILS-1:0] rail_en_q, rail_en_d;
    logic                 pwr_ok_q, pwr_ok_d;
    logic                 busy_q, busy_d;
    logic                 fault_q, fault_d;
    logic [IDX_W-1:0]     fault_rail_q, fault_rail_d;

    logic [NUM_RAILS-1:0] settled;
    logic [NUM_RAILS-1:0] drop_vec;
    logic [IDX_W-1:0]     drop_idx;
    logic                 drop_hit;
    logic                 timeout_hit;
    logic                 pg_cur;
    logic [IDX_W-1:0]     idx_inc;
    logic [IDX_W-1:0]     idx_dec;

    // Rails below idx have already settled; in ON every rail is settled.
    always_comb begin
        settled = '0;
        for (int j = 0; j < NUM_RAILS; j++) begin
            settled[j] = (state_q == S_ON) || (j < int'(idx_q));
        end
        drop_vec = settled & ~pg;
        drop_idx = '0;
        for (int j = NUM_RAILS - 1; j >= 0; j--) begin
            if (drop_vec[j]) begin
                drop_idx = IDX_W'(j);
            end
        end
        drop_hit = (state_q == S_WAIT_PG || state_q == S_SETTLE || state_q == S_ON) &&
                   (|drop_vec);
    end

    assign pg_cur      = pg[idx_q];
    assign timeout_hit = (state_q == S_WAIT_PG) && !pg_cur && (cnt_q == TIMEOUT_LAST);
    assign idx_inc     = idx_q + 1'b1;
    assign idx_dec     = idx_q - 1'b1;

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        rail_en_d    = rail_en_q;
        fault_d      = fault_q;
        fault_rail_d = fault_rail_q;

        if (drop_hit || timeout_hit) begin
            state_d      = S_FAULT;
            rail_en_d    = '0;
            cnt_d        = '0;
            fault_d      = 1'b1;
            fault_rail_d = drop_hit ? drop_idx : idx_q;
        end else begin
            case (state_q)
                S_OFF: begin
                    if (sys_on) begin
                        state_d   = S_WAIT_PG;
                        idx_d     = '0;
                        cnt_d     = '0;
                        rail_en_d = ONE_HOT0;
                    end
                end
                S_WAIT_PG: begin
                    if (!sys_on) begin
                        state_d   = S_DOWN;
                        rail_en_d = rail_en_q & ~(ONE_HOT0 << idx_q);
                        cnt_d     = '0;
                    end else if (pg_cur) begin
                        state_d = S_SETTLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_SETTLE: begin
                    if (!sys_on) begin
                        state_d   = S_DOWN;
                        rail_en_d = rail_en_q & ~(ONE_HOT0 << idx_q);
                        cnt_d     = '0;
                    end else if (!pg_cur) begin
                        // A glitch discards the settle progress and reopens the timeout window.
                        state_d = S_WAIT_PG;
                        cnt_d   = '0;
                    end else if (cnt_q == SETTLE_LAST) begin
                        cnt_d = '0;
                        if (idx_q == LAST_IDX) begin
                            state_d = S_ON;
                        end else begin
                            state_d   = S_WAIT_PG;
                            idx_d     = idx_inc;
                            rail_en_d = rail_en_q | (ONE_HOT0 << idx_inc);
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_ON: begin
                    if (!sys_on) begin
                        state_d   = S_DOWN;
                        idx_d     = LAST_IDX;
                        rail_en_d = rail_en_q & ~(ONE_HOT0 << LAST_IDX);
                        cnt_d     = '0;
                    end
                end
                S_DOWN: begin
                    if (cnt_q == GAP_LAST) begin
                        cnt_d = '0;
                        if (idx_q != '0) begin
                            idx_d     = idx_dec;
                            rail_en_d = rail_en_q & ~(ONE_HOT0 << idx_dec);
                        end else begin
                            state_d = S_OFF;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_FAULT: begin
                    if (!sys_on) begin
                        state_d      = S_OFF;
                        fault_d      = 1'b0;
                        fault_rail_d = '0;
                    end
                end
                default: begin
                    state_d   = S_OFF;
                    idx_d     = '0;
                    cnt_d     = '0;
                    rail_en_d = '0;
                end
            endcase
        end

        pwr_ok_d = (state_d == S_ON);
        busy_d   = (state_d == S_WAIT_PG) || (state_d == S_SETTLE) || (state_d == S_DOWN);
    end

    // Reset is the emergency path: every enable drops at once, no reverse ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_OFF;
            idx_q        <= '0;
            cnt_q        <= '0;
            rail_en_q    <= '0;
            pwr_ok_q     <= 1'b0;
            busy_q       <= 1'b0;
            fault_q      <= 1'b0;
            fault_rail_q <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            rail_en_q    <= rail_en_d;
            pwr_ok_q     <= pwr_ok_d;
            busy_q       <= busy_d;
            fault_q      <= fault_d;
            fault_rail_q <= fault_rail_d;
        end
    end

    assign rail_en    = rail_en_q;
    assign pwr_ok     = pwr_ok_q;
    assign busy       = busy_q;
    assign fault      = fault_q;
    assign fault_rail = fault_rail_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_power_seq_ctrl.sv
// Randomized scenario bench for power_seq_ctrl: a timeline planner predicts every output
// change from the sequencing rules, and a negedge monitor pops and compares each one.
module tb_power_seq_ctrl;

    localparam int NR  = 4;
    localparam int SC  = 30;
    localparam int TO  = 100;
    localparam int GAP = 10;
    localparam int NEVER = 1 << 30;

    logic       clk;
    logic       reset;
    logic       sys_on;
    logic [3:0] pg;
    logic [3:0] rail_en;
    logic       pwr_ok;
    logic       busy;
    logic       fault;
    logic [1:0] fault_rail;
    logic [2:0] dbg_state;

    power_seq_ctrl #(
        .NUM_RAILS      (NR),
        .SETTLE_CYC     (SC),
        .PG_TIMEOUT_CYC (TO),
        .OFF_GAP_CYC    (GAP)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .sys_on     (sys_on),
        .pg         (pg),
        .rail_en    (rail_en),
        .pwr_ok     (pwr_ok),
        .busy       (busy),
        .fault      (fault),
        .fault_rail (fault_rail),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock / reset / cycle count ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc;
    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
        end
    end

    // ---------------- scoreboard state ----------------
    logic [40:0] exp_q[$];
    logic [40:0] ev;
    logic [8:0]  obs;
    logic [8:0]  prev_obs;
    logic        mon_en;
    int          n_checks;
    int          n_pass;

    // per-rail power-good plan, in absolute edge numbers
    int rise[NR];
    int glo[NR];
    int ghi[NR];
    int drop[NR];

    function automatic logic [8:0] pack_obs(input logic [3:0] en, input logic ok,
                                            input logic bz, input logic fl,
                                            input logic [1:0] fr);
        return {en, ok, bz, fl, (fl ? fr : 2'b00)};
    endfunction

    function automatic logic [3:0] pg_at(input int e);
        logic [3:0] v;
        for (int i = 0; i < NR; i++) begin
            v[i] = (e >= rise[i]) && !(e >= glo[i] && e <= ghi[i]) && (e < drop[i]);
        end
        return v;
    endfunction

    task automatic clear_plan();
        for (int i = 0; i < NR; i++) begin
            rise[i] = NEVER;
            glo[i]  = NEVER;
            ghi[i]  = NEVER;
            drop[i] = NEVER;
        end
    endtask

    task automatic drop_all(input int e);
        for (int i = 0; i < NR; i++) drop[i] = e;
    endtask

    task automatic push_ev(input int e, input logic [3:0] en, input logic ok,
                           input logic bz, input logic fl, input logic [1:0] fr);
        exp_q.push_back({32'(e), pack_obs(en, ok, bz, fl, fr)});
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        n_checks++;
        if (got !== req) $display("FAIL %s got=%0h required=%0h", name, got, req);
        else n_pass++;
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (mon_en) begin
            obs = pack_obs(rail_en, pwr_ok, busy, fault, fault_rail);
            if (obs !== prev_obs) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL unexpected_change cyc=%0d got=%b state=%0d", cyc, obs, dbg_state);
                end else begin
                    ev = exp_q.pop_front();
                    if (ev[40:9] !== 32'(cyc) || ev[8:0] !== obs)
                        $display("FAIL event got cyc=%0d val=%b required cyc=%0d val=%b state=%0d",
                                 cyc, obs, ev[40:9], ev[8:0], dbg_state);
                    else n_pass++;
                end
                prev_obs = obs;
            end
            if (pwr_ok) begin
                n_checks++;
                if (rail_en !== 4'hF) $display("FAIL pwr_ok_invariant cyc=%0d rail_en=%b required=1111", cyc, rail_en);
                else n_pass++;
            end
        end
    end

    // ---------------- drivers ----------------
    initial begin
        pg = '0;
        forever begin
            @(posedge clk);
            #2;
            pg = pg_at(cyc + 1);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic step_to(input int e);
        int guard;
        guard = 0;
        while (cyc < e && guard < 5000) begin
            step();
            guard++;
        end
    endtask

    task automatic drain(input string name, input int budget);
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < budget) begin
            step();
            n++;
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            $display("FAIL %s_pending got=%0d events left required=0", name, exp_q.size());
            exp_q.delete();
        end else n_pass++;
        repeat (5) step();
    endtask

    // Reverse-order shutdown starting with rail top cleared at edge a.
    task automatic push_down(input int a, input int top);
        for (int m = 0; m <= top; m++) push_ev(a + GAP * m, 4'((1 << (top - m)) - 1), 1'b0, 1'b1, 1'b0, 2'd0);
        push_ev(a + GAP * (top + 1), 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0);
    endtask

    // Plans a power-up with rail 0 enabled at edge t. end_edge is the ON edge, the fault
    // edge (fail_rail), or the abort edge (abort_rail, abort_off clocks into its settle).
    task automatic plan_up(input int t, input int fail_rail, input int glitch_rail,
                           input int abort_rail, input int abort_off, output int end_edge);
        int en, s, d, k, g;
        bit done;
        en = t;
        end_edge = t;
        done = 1'b0;
        push_ev(t, 4'b0001, 1'b0, 1'b1, 1'b0, 2'd0);
        for (int i = 0; i < NR; i++) begin
            if (!done) begin
                if (i == fail_rail) begin
                    end_edge = en + TO;
                    push_ev(end_edge, 4'b0000, 1'b0, 1'b0, 1'b1, 2'(i));
                    done = 1'b1;
                end else begin
                    d = $urandom_range(1, 20);
                    s = en + d;
                    rise[i] = s;
                    if (i == glitch_rail) begin
                        k = $urandom_range(0, SC - 3);
                        g = $urandom_range(1, 5);
                        glo[i] = s + k + 1;
                        ghi[i] = s + k + g;
                        s = s + k + g + 1;
                    end
                    if (i == abort_rail) begin
                        end_edge = s + 1 + abort_off;
                        done = 1'b1;
                    end else if (i < NR - 1) begin
                        en = s + SC;
                        push_ev(en, 4'((1 << (i + 2)) - 1), 1'b0, 1'b1, 1'b0, 2'd0);
                    end else begin
                        end_edge = s + SC;
                        push_ev(end_edge, 4'hF, 1'b1, 1'b0, 1'b0, 2'd0);
                    end
                end
            end
        end
    endtask

    function automatic int lowest_bit(input logic [3:0] m);
        int r;
        r = 0;
        for (int i = NR - 1; i >= 0; i--) if (m[i]) r = i;
        return r;
    endfunction

    // ---------------- scenarios ----------------
    initial begin
        int t, e, d_edge, f, a, o, x, typ;
        logic [3:0] msk;
        n_checks = 0;
        n_pass   = 0;
        mon_en   = 1'b0;
        prev_obs = '0;
        reset    = 1'b1;
        sys_on   = 1'b0;
        clear_plan();
        #3;
        check("reset_rail_en", 32'(rail_en), 32'h0);
        check("reset_pwr_ok", 32'(pwr_ok), 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        check("reset_fault", 32'(fault), 32'h0);
        check("reset_fault_rail", 32'(fault_rail), 32'h0);
        repeat (3) step();
        reset = 1'b0;
        mon_en = 1'b1;
        step();

        for (int it = 0; it < 10; it++) begin
            typ = (it < 4) ? it : $urandom_range(0, 3);
            clear_plan();
            step();
            t = cyc + 1;
            case (typ)
                0: begin
                    plan_up(t, -1, $urandom_range(0, 3), -1, 0, e);
                    sys_on = 1'b1;
                    step_to(e + $urandom_range(1, 20));
                    d_edge = cyc + 1;
                    push_down(d_edge, NR - 1);
                    drop_all(d_edge + 1);
                    sys_on = 1'b0;
                    drain("power_down", 200);
                end
                1: begin
                    f = $urandom_range(0, 3);
                    plan_up(t, f, $urandom_range(0, 3), -1, 0, e);
                    sys_on = 1'b1;
                    step_to(e + $urandom_range(1, 30));
                    push_ev(cyc + 1, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0);
                    sys_on = 1'b0;
                    drain("timeout_clear", 100);
                end
                2: begin
                    plan_up(t, -1, $urandom_range(0, 3), -1, 0, e);
                    sys_on = 1'b1;
                    step_to(e + $urandom_range(1, 20));
                    msk = 4'($urandom_range(1, 15));
                    for (int i = 0; i < NR; i++) if (msk[i]) drop[i] = cyc + 1;
                    push_ev(cyc + 1, 4'b0000, 1'b0, 1'b0, 1'b1, 2'(lowest_bit(msk)));
                    step_to(cyc + $urandom_range(2, 20));
                    push_ev(cyc + 1, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0);
                    sys_on = 1'b0;
                    drain("settled_drop", 100);
                end
                default: begin
                    a = $urandom_range(0, 3);
                    o = $urandom_range(0, SC - 2);
                    plan_up(t, -1, -1, a, o, e);
                    sys_on = 1'b1;
                    step_to(e - 1);
                    sys_on = 1'b0;
                    push_down(e, a);
                    drop_all(e + 1);
                    if ($urandom_range(0, 1) == 1) begin
                        x = e + GAP * (a + 1);
                        step_to(e + $urandom_range(1, GAP * (a + 1) - 1));
                        sys_on = 1'b1;
                        push_ev(x + 1, 4'b0001, 1'b0, 1'b1, 1'b0, 2'd0);
                        push_down(x + 2, 0);
                        step_to(x + 1);
                        sys_on = 1'b0;
                    end
                    drain("abort", 200);
                end
            endcase
        end

        // Async reset in the middle of a power-down.
        clear_plan();
        step();
        t = cyc + 1;
        plan_up(t, -1, -1, -1, 0, e);
        sys_on = 1'b1;
        step_to(e + 3);
        d_edge = cyc + 1;
        push_ev(d_edge, 4'b0111, 1'b0, 1'b1, 1'b0, 2'd0);
        push_ev(d_edge + GAP, 4'b0011, 1'b0, 1'b1, 1'b0, 2'd0);
        drop_all(d_edge + 1);
        sys_on = 1'b0;
        step_to(d_edge + GAP + 5);
        check("pre_reset_events_left", 32'(exp_q.size()), 32'h0);
        mon_en = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check("async_rail_en", 32'(rail_en), 32'h0);
        check("async_pwr_ok", 32'(pwr_ok), 32'h0);
        check("async_busy", 32'(busy), 32'h0);
        check("async_fault", 32'(fault), 32'h0);
        step();
        reset = 1'b0;
        repeat (3) step();
        check("post_reset_rail_en", 32'(rail_en), 32'h0);
        check("post_reset_busy", 32'(busy), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
